mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/md_pkg.sv | 30 +++
 rtl/md_calc.sv | 48 ++++
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types for the multiply/divide unit: op encoding, FSM states, default latencies.
// The DIV state only exists when MD_DIV_EN is defined.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

`ifdef MD_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1
    } md_state_e;
`endif

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

endpackage

// File: rtl/md_calc.sv
// Combinational datapath: 64-bit product and, with MD_DIV_EN, truncating quotient/remainder.
// Works purely on the operands latched by mult_div_unit.
module md_calc
    import md_pkg::*;
(
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [63:0] product
`ifdef MD_DIV_EN
    ,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
`endif
);

    logic [63:0] ext_a;
    logic [63:0] ext_b;

    // Sign-extending to 64 bits makes the modulo-2^64 product correct for both signednesses.
    assign ext_a   = {{32{is_signed & op_a[31]}}, op_a};
    assign ext_b   = {{32{is_signed & op_b[31]}}, op_b};
    assign product = ext_a * ext_b;

`ifdef MD_DIV_EN
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    assign neg_a       = is_signed & op_a[31];
    assign neg_b       = is_signed & op_b[31];
    assign mag_a       = neg_a ? (32'd0 - op_a) : op_a;
    assign mag_b       = neg_b ? (32'd0 - op_b) : op_b;
    assign div_by_zero = (op_b == 32'd0);
    // Divide by 1 instead of 0 so the datapath never goes X; the result is discarded anyway.
    assign safe_b      = div_by_zero ? 32'd1 : mag_b;
    assign q_mag       = mag_a / safe_b;
    assign r_mag       = mag_a % safe_b;
    assign quotient    = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    assign remainder   = neg_a ? (32'd0 - r_mag) : r_mag;
`endif

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with busy/stall handshake for the D-stage hazard logic.
// Divide support is compiled in only when MD_DIV_EN is defined.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               sgn_q, sgn_d;
    logic               long_op;
    logic [63:0]        product;
    md_op_e             op_e;

    assign op_e = md_op_e'(op);

`ifdef MD_DIV_EN
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    md_calc u_calc (
        .is_signed  (sgn_q),
        .op_a       (a_q),
        .op_b       (b_q),
        .product    (product),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );
`else
    md_calc u_calc (
        .is_signed(sgn_q),
        .op_a     (a_q),
        .op_b     (b_q),
        .product  (product)
    );
`endif

    always_comb begin
        long_op = 1'b0;
        case (op_e)
            OP_MULT, OP_MULTU: long_op = 1'b1;
`ifdef MD_DIV_EN
            OP_DIV, OP_DIVU:   long_op = 1'b1;
`endif
            default:           long_op = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op_e)
                        OP_MULT, OP_MULTU: begin
                            a_d     = rs_val;
                            b_d     = rt_val;
                            sgn_d   = (op_e == OP_MULT);
                            cnt_d   = CNT_W'(MULT_LAT);
                            state_d = ST_MUL;
                            busy_d  = 1'b1;
                        end
`ifdef MD_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            a_d     = rs_val;
                            b_d     = rt_val;
                            sgn_d   = (op_e == OP_DIV);
                            cnt_d   = CNT_W'(DIV_LAT);
                            state_d = ST_DIV;
                            busy_d  = 1'b1;
                        end
`endif
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
`ifdef MD_DIV_EN
            ST_DIV: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (!div_by_zero) begin
                        hi_d = remainder;
                        lo_d = quotient;
                    end
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
        end
    end

    assign busy     = busy_q;
    assign md_stall = busy_q | (start & long_op);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO queued at issue, popped when the op retires.
// DIV expectations follow whether MD_DIV_EN is defined for this build.
module tb_mult_div_unit;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic [2:0]  op     = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                           MTHI = 3'd4, MTLO = 3'd5, UNDEF = 3'd6;
`ifdef MD_DIV_EN
    localparam int DL = 10;
`else
    localparam int DL = 0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cur_hi   = 32'd0;
    logic [31:0] cur_lo   = 32'd0;

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .busy    (busy),
        .md_stall(md_stall),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, hold it a single cycle, scramble operands, then measure busy and retire.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        int   n;
        exp_q.push_back('{hi: eh, lo: el});
        cur_hi = eh;
        cur_lo = el;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        #1;
        check({tag, "_stall"}, md_stall, (lat > 0));
        @(negedge clk);
        start  = 1'b0;
        rs_val = ~a;
        rt_val = ~b + 32'd7;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, n, lat);
        e = exp_q.pop_front();
        check({tag, "_hi"}, hi, e.hi);
        check({tag, "_lo"}, lo, e.lo);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] p;
        int          n;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_stall", md_stall, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;

        do_op("mult_neg", MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        do_op("mtlo", MTLO, 32'h0000_1234, 32'd0, 0, cur_hi, 32'h0000_1234);
        do_op("mthi", MTHI, 32'h0000_CAFE, 32'd0, 0, 32'h0000_CAFE, cur_lo);

`ifdef MD_DIV_EN
        do_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, DL, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_zero", DIV, 32'hFFFF_FFF9, 32'd0, DL, cur_hi, cur_lo);
        do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, DL, 32'd0, 32'h8000_0000);
        do_op("divu", DIVU, 32'd10, 32'd3, DL, 32'd1, 32'd3);
        do_op("div_pos_negd", DIV, 32'd7, 32'hFFFF_FFFE, DL, 32'd1, 32'hFFFF_FFFD);
`else
        do_op("div_off", DIV, 32'hFFFF_FFF9, 32'd2, DL, cur_hi, cur_lo);
        do_op("divu_off", DIVU, 32'd10, 32'd3, DL, cur_hi, cur_lo);
`endif

        do_op("undef_op", UNDEF, 32'hDEAD_BEEF, 32'd5, 0, cur_hi, cur_lo);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            p  = 64'(longint'(int'(ra)) * longint'(int'(rb)));
            do_op("mult_rand", MULT, ra, rb, 5, p[63:32], p[31:0]);
            p  = 64'(ra) * 64'(rb);
            do_op("multu_rand", MULTU, ra, rb, 5, p[63:32], p[31:0]);
        end

        // MTHI arriving while a multiply is in flight must be dropped.
        @(negedge clk);
        start  = 1'b1;
        op     = MULT;
        rs_val = 32'd7;
        rt_val = 32'd6;
        @(negedge clk);
        op     = MTHI;
        rs_val = 32'hDEAD_0000;
        #1;
        check("mthi_busy_stall", md_stall, 1'b1);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("mthi_busy_cycles", n, 4);
        check("mthi_busy_hi", hi, 32'd0);
        check("mthi_busy_lo", lo, 32'd42);

        // Reset in the third busy cycle of the longest op aborts without commit.
        @(negedge clk);
        start  = 1'b1;
`ifdef MD_DIV_EN
        op     = DIV;
`else
        op     = MULT;
`endif
        rs_val = 32'd100;
        rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (15) @(negedge clk);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);
        check("abort_late_busy", busy, 1'b0);

        // Reset beats a simultaneous MTLO.
        reset  = 1'b1;
        start  = 1'b1;
        op     = MTLO;
        rs_val = 32'h0000_0055;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_prio_lo", lo, 32'd0);
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        do_op("post_rst_mult", MULT, 32'd123, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 32'hFFFF_FF85);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
